fuzz_stim_sequencer: RTL and testbench
======================================

// Module: fuzz_stim_sequencer
// PURPOSE
//  Synthesizable stimulus sequencer/controller for a fuzz DUT with flat in/out buses.
//  Per run it:
//    - resets the DUT;
//    - generates LCG pseudo-random input vectors, one 32-bit word per clock;
//    - applies each vector and waits a settle window;
//    - compacts the DUT output into a 32-bit MISR signature.
//  Sits between the run-control logic and the DUT, replacing the behavioural stimulus loop,
//  so runs are repeatable on FPGA.
// PARAMETERS
//  IN_W     261  width of DUT input bus dut_in_flat
//  OUT_W    330  width of DUT output bus dut_out_flat
//  CYC_W    16   width of the vector-count request/counter
//  RST_CYC  2    cycles dut_rst_n is held low at run start (>=1)
//  SETTLE   1    cycles each vector is held before output is sampled (>=1)
// PORTS
//  clk           in   1        single clock, all logic on posedge
//  rst           in   1        asynchronous, active-high reset
//  start         in   1        1-cycle run request; sampled only in IDLE/DONE
//  abort         in   1        synchronous run abort
//  seed_i        in   32       LCG seed, captured on accepted start
//  cycles_i      in   CYC_W    number of vectors to apply, captured on accepted start
//  busy          out  1        high from accepted start until DONE/IDLE entry
//  done          out  1        1-cycle pulse when the last vector is sampled
//  dut_rst_n     out  1        DUT reset (active-low), registered
//  dut_in_flat   out  IN_W     DUT input vector, registered
//  dut_out_flat  in   OUT_W    DUT output bus
//  signature     out  32       MISR result, stable after done until next start
//  vec_cnt       out  CYC_W    vectors sampled so far in this run
// BEHAVIOUR
//  Reset values: busy=0, done=0, dut_rst_n=0, dut_in_flat=0, signature=0, vec_cnt=0, state=IDLE.
//  LCG: s_next = s*32'h41C64E6D + 32'h3039 (mod 2^32). Each generated word = s_next.
//    NW = ceil(IN_W/32) words per vector; word k fills bits [32k+31:32k].
//    The last word is truncated to its low (IN_W-32*(NW-1)) bits.
//  States:
//    IDLE:   start -> RSTP. Captures seed/cycles, signature=0, vec_cnt=0, busy=1, dut_rst_n=0.
//    RSTP:   RST_CYC cycles with dut_rst_n=0; then dut_rst_n=1.
//            cycles==0 -> DONE, otherwise -> GEN.
//    GEN:    NW cycles, one word per cycle into a shadow register.
//            On the NW-th cycle dut_in_flat <= full shadow, in a single update.
//            The DUT never sees a partial vector. -> WAIT.
//    WAIT:   SETTLE cycles; dut_in_flat held. On the last WAIT cycle:
//            signature <= {sig[30:0], sig[31]^sig[21]^sig[1]^sig[0]} ^ fold(dut_out_flat).
//            fold = XOR of all 32-bit chunks of dut_out_flat, top chunk zero-extended.
//            vec_cnt increments. If vec_cnt+1==cycles -> DONE with done=1, else -> GEN.
//    DONE:   busy=0. dut_rst_n stays 1 and dut_in_flat holds its last value.
//            start -> RSTP as from IDLE.
//  Per-vector latency: NW+SETTLE cycles. Run length: RST_CYC + cycles*(NW+SETTLE).
//  LCG state is not reseeded between vectors, so the sequence is continuous across a run.
//  start while busy: ignored. start and abort in the same cycle: abort wins.
//  abort while busy -> IDLE next cycle:
//    busy=0, done not pulsed, dut_rst_n=0, signature/vec_cnt keep partial values.
//  cycles_i = max (2^CYC_W-1): vec_cnt reaches max exactly at DONE, no wrap.
//  rst asserted mid-run: all state and outputs go to reset values immediately; no done pulse.
// TESTING
//  1. seed_i=0, cycles_i=1, NW=9 -> after RSTP, dut_in_flat[31:0]=32'h00003039 and
//     [63:32]=32'hD3DC167E. done pulses exactly 2+9+1=12 cycles after start; vec_cnt=1.
//  2. seed_i=32'h877409A9, cycles_i=100, DUT=pass-through stub -> done at cycle 2+100*10.
//     signature matches the reference model's LCG+MISR; two identical runs give equal signature.
//  3. cycles_i=0 -> dut_rst_n low for 2 cycles then high, DONE immediately, done pulses,
//     signature=0, vec_cnt=0.
//  4. abort in GEN of vector 5 -> IDLE next cycle, busy=0, no done, dut_rst_n=0, vec_cnt=4.
//     A following start runs cleanly.
//  5. start pulsed while busy (vector 3) -> ignored, run completes with the original cycles_i.
//     start asserted together with abort -> abort taken.
//  6. rst pulse during WAIT -> all outputs at reset values within the same cycle;
//     no done pulse afterwards.

Source files
------------

// File: rtl/fuzz_stim_sequencer.sv
// Stimulus sequencer for a fuzz DUT: resets it, streams LCG-generated input vectors,
// and compacts every sampled output into a 32-bit MISR signature.
module fuzz_stim_sequencer #(
  parameter int IN_W    = 261,
  parameter int OUT_W   = 330,
  parameter int CYC_W   = 16,
  parameter int RST_CYC = 2,
  parameter int SETTLE  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [31:0]        seed_i,
  input  logic [CYC_W-1:0]   cycles_i,
  output logic               busy,
  output logic               done,
  output logic               dut_rst_n,
  output logic [IN_W-1:0]    dut_in_flat,
  input  logic [OUT_W-1:0]   dut_out_flat,
  output logic [31:0]        signature,
  output logic [CYC_W-1:0]   vec_cnt
);

  localparam int NW    = (IN_W + 31) / 32;
  localparam int OC    = (OUT_W + 31) / 32;
  localparam int SH_W  = NW * 32;
  localparam int CMAX  = (RST_CYC > NW) ? ((RST_CYC > SETTLE) ? RST_CYC : SETTLE)
                                        : ((NW > SETTLE) ? NW : SETTLE);
  localparam int CNT_W = $clog2(CMAX + 1);
  localparam logic [31:0] LCG_A = 32'h41C64E6D;
  localparam logic [31:0] LCG_C = 32'h00003039;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RSTP = 3'd1,
    S_GEN  = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // XOR of all 32-bit chunks of the DUT output, top chunk zero-extended.
  function automatic logic [31:0] fold32(input logic [OUT_W-1:0] v);
    logic [OC*32-1:0] ext;
    logic [31:0]      acc;
    ext = '0;
    ext[OUT_W-1:0] = v;
    acc = 32'h0000_0000;
    for (int k = 0; k < OC; k++) begin
      acc = acc ^ ext[k*32 +: 32];
    end
    return acc;
  endfunction

  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] f);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ f;
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       lcg_q, lcg_d;
  logic [SH_W-1:0]   shadow_q, shadow_d;
  logic [CYC_W-1:0]  cycles_q, cycles_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              dut_rst_n_q, dut_rst_n_d;
  logic [IN_W-1:0]   dut_in_q, dut_in_d;
  logic [31:0]       sig_q, sig_d;
  logic [CYC_W-1:0]  vec_cnt_q, vec_cnt_d;
  logic [31:0]       word_s;

  // Next-state and next-output computation for the whole sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lcg_d       = lcg_q;
    shadow_d    = shadow_q;
    cycles_d    = cycles_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dut_rst_n_d = dut_rst_n_q;
    dut_in_d    = dut_in_q;
    sig_d       = sig_q;
    vec_cnt_d   = vec_cnt_q;
    word_s      = lcg_q * LCG_A + LCG_C;

    // busy is high exactly in RSTP/GEN/WAIT, so it doubles as the abort qualifier
    if (abort && busy_q) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      busy_d      = 1'b0;
      dut_rst_n_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start && !abort) begin
            state_d     = S_RSTP;
            cnt_d       = '0;
            lcg_d       = seed_i;
            cycles_d    = cycles_i;
            sig_d       = 32'h0000_0000;
            vec_cnt_d   = '0;
            busy_d      = 1'b1;
            dut_rst_n_d = 1'b0;
          end else begin
            state_d = state_q;
          end
        end
        S_RSTP: begin
          if (cnt_q == CNT_W'(RST_CYC - 1)) begin
            cnt_d       = '0;
            dut_rst_n_d = 1'b1;
            if (cycles_q == '0) begin
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = S_GEN;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_GEN: begin
          lcg_d = word_s;
          for (int k = 0; k < NW; k++) begin
            if (cnt_q == CNT_W'(k)) begin
              shadow_d[k*32 +: 32] = word_s;
            end else begin
              shadow_d[k*32 +: 32] = shadow_q[k*32 +: 32];
            end
          end
          // whole vector lands at once so the DUT never sees a half-built input
          if (cnt_q == CNT_W'(NW - 1)) begin
            dut_in_d = shadow_d[IN_W-1:0];
            cnt_d    = '0;
            state_d  = S_WAIT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (cnt_q == CNT_W'(SETTLE - 1)) begin
            cnt_d     = '0;
            sig_d     = misr_step(sig_q, fold32(dut_out_flat));
            vec_cnt_d = vec_cnt_q + CYC_W'(1);
            if (vec_cnt_d == cycles_q) begin
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = S_GEN;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and registered-output flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lcg_q       <= 32'h0000_0000;
      shadow_q    <= '0;
      cycles_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dut_rst_n_q <= 1'b0;
      dut_in_q    <= '0;
      sig_q       <= 32'h0000_0000;
      vec_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lcg_q       <= lcg_d;
      shadow_q    <= shadow_d;
      cycles_q    <= cycles_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dut_rst_n_q <= dut_rst_n_d;
      dut_in_q    <= dut_in_d;
      sig_q       <= sig_d;
      vec_cnt_q   <= vec_cnt_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign dut_rst_n   = dut_rst_n_q;
  assign dut_in_flat = dut_in_q;
  assign signature   = sig_q;
  assign vec_cnt     = vec_cnt_q;

endmodule

// File: tb/tb_fuzz_stim_sequencer.sv
// Scoreboard bench for fuzz_stim_sequencer: a plain-arithmetic LCG/MISR model predicts each
// run's signature, count and completion cycle; a monitor checks them whenever done pulses.
module tb_fuzz_stim_sequencer;

  localparam int IN_W    = 261;
  localparam int OUT_W   = 330;
  localparam int CYC_W   = 16;
  localparam int RST_CYC = 2;
  localparam int SETTLE  = 1;
  localparam int NW      = (IN_W + 31) / 32;
  localparam int OC      = (OUT_W + 31) / 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [31:0]       seed_i = 32'h0;
  logic [CYC_W-1:0]  cycles_i = '0;
  logic              busy, done, dut_rst_n;
  logic [IN_W-1:0]   dut_in_flat;
  logic [OUT_W-1:0]  dut_out_flat;
  logic [31:0]       signature;
  logic [CYC_W-1:0]  vec_cnt;

  typedef struct {
    logic [31:0]      sig;
    logic [CYC_W-1:0] cnt;
    int               at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  // Stand-in DUT: output is the input plus a scrambled copy of its low bits.
  function automatic logic [OUT_W-1:0] stub(input logic [IN_W-1:0] v);
    return {v[OUT_W-IN_W-1:0] ^ 69'h1_5A5A_F00F_1234_C3C3, v};
  endfunction

  assign dut_out_flat = stub(dut_in_flat);

  fuzz_stim_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .CYC_W(CYC_W),
                        .RST_CYC(RST_CYC), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .seed_i(seed_i), .cycles_i(cycles_i),
    .busy(busy), .done(done), .dut_rst_n(dut_rst_n),
    .dut_in_flat(dut_in_flat), .dut_out_flat(dut_out_flat),
    .signature(signature), .vec_cnt(vec_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] fold_ref(input logic [OUT_W-1:0] o);
    logic [OC*32-1:0] e;
    logic [31:0]      a;
    e = '0;
    e[OUT_W-1:0] = o;
    a = 32'h0;
    for (int k = 0; k < OC; k++) a = a ^ e[k*32 +: 32];
    return a;
  endfunction

  // Reference run: n vectors from a continuous LCG stream, compacted into the MISR.
  function automatic logic [31:0] model_run(input logic [31:0] seed, input int n,
                                            output logic [IN_W-1:0] last_vec);
    logic [31:0]      s;
    logic [31:0]      sig;
    logic [NW*32-1:0] w;
    s = seed;
    sig = 32'h0;
    last_vec = '0;
    for (int v = 0; v < n; v++) begin
      w = '0;
      for (int k = 0; k < NW; k++) begin
        s = s * 32'h41C64E6D + 32'h00003039;
        w[k*32 +: 32] = s;
      end
      last_vec = w[IN_W-1:0];
      sig = {sig[30:0], sig[31] ^ sig[21] ^ sig[1] ^ sig[0]} ^ fold_ref(stub(last_vec));
    end
    return sig;
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest predicted run.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, expected no done", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_signature", 512'(signature), 512'(mon_e.sig));
        chk("sb_vec_cnt", 512'(vec_cnt), 512'(mon_e.cnt));
        chk("sb_done_cycle", 512'(cyc), 512'(mon_e.at));
        chk("sb_busy_at_done", 512'(busy), 512'(1'b0));
      end
    end
  end

  task automatic do_start(input logic [31:0] seed, input int n, input bit push);
    exp_t             e;
    logic [IN_W-1:0]  lv;
    @(negedge clk);
    seed_i   = seed;
    cycles_i = CYC_W'(n);
    start    = 1'b1;
    if (push) begin
      e.sig = model_run(seed, n, lv);
      e.cnt = CYC_W'(n);
      e.at  = cyc + 1 + RST_CYC + n * (NW + SETTLE);
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_sb(input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d runs still pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IN_W-1:0] prev, lv;
    logic [31:0]     psig;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 512'(busy), 512'(1'b0));
    chk("rst_done", 512'(done), 512'(1'b0));
    chk("rst_dut_rst_n", 512'(dut_rst_n), 512'(1'b0));
    chk("rst_dut_in", 512'(dut_in_flat), 512'(0));
    chk("rst_signature", 512'(signature), 512'(0));
    chk("rst_vec_cnt", 512'(vec_cnt), 512'(0));

    // Single vector from seed 0: reset window, no partial updates, known first words.
    prev = dut_in_flat;
    do_start(32'h0, 1, 1'b1);
    chk("t1_busy", 512'(busy), 512'(1'b1));
    chk("t1_rstn_c1", 512'(dut_rst_n), 512'(1'b0));
    @(negedge clk);
    chk("t1_rstn_c2", 512'(dut_rst_n), 512'(1'b0));
    @(negedge clk);
    chk("t1_rstn_high", 512'(dut_rst_n), 512'(1'b1));
    for (int k = 0; k < NW; k++) begin
      chk("t1_no_partial", 512'(dut_in_flat), 512'(prev));
      @(negedge clk);
    end
    void'(model_run(32'h0, 1, lv));
    chk("t1_word0", 512'(dut_in_flat[31:0]), 512'(32'h00003039));
    chk("t1_word1", 512'(dut_in_flat[63:32]), 512'(32'hD3DC167E));
    chk("t1_vector", 512'(dut_in_flat), 512'(lv));
    wait_sb(50);

    // Long run, repeated: both must hit the model signature at cycle 2+100*10.
    for (int r = 0; r < 2; r++) begin
      do_start(32'h877409A9, 100, 1'b1);
      wait_sb(1200);
    end

    for (int r = 0; r < 4; r++) begin
      do_start($urandom, int'($urandom_range(1, 12)), 1'b1);
      wait_sb(200);
    end

    // Zero vectors: reset pulse then immediate done with zero signature/count.
    do_start($urandom, 0, 1'b1);
    chk("t3_rstn_c1", 512'(dut_rst_n), 512'(1'b0));
    @(negedge clk);
    chk("t3_rstn_c2", 512'(dut_rst_n), 512'(1'b0));
    @(negedge clk);
    chk("t3_rstn_high", 512'(dut_rst_n), 512'(1'b1));
    wait_sb(20);

    // Abort during GEN of the fifth vector keeps partial results.
    seed_i = $urandom;
    psig = model_run(seed_i, 4, lv);
    do_start(seed_i, 10, 1'b0);
    repeat (44) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_busy", 512'(busy), 512'(1'b0));
    chk("t4_done", 512'(done), 512'(1'b0));
    chk("t4_rstn", 512'(dut_rst_n), 512'(1'b0));
    chk("t4_vec_cnt", 512'(vec_cnt), 512'(4));
    chk("t4_partial_sig", 512'(signature), 512'(psig));
    repeat (30) @(negedge clk);
    do_start($urandom, 3, 1'b1);
    wait_sb(100);

    // start while busy is ignored; start+abort together in DONE takes the abort.
    do_start($urandom, 6, 1'b1);
    repeat (24) @(negedge clk);
    seed_i   = $urandom;
    cycles_i = CYC_W'(2);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_sb(150);
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("t5_abort_wins_busy", 512'(busy), 512'(1'b0));
    chk("t5_abort_wins_rstn", 512'(dut_rst_n), 512'(1'b1));
    repeat (20) @(negedge clk);

    // Async reset during WAIT clears everything at once and suppresses done.
    do_start($urandom, 5, 1'b0);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_busy", 512'(busy), 512'(1'b0));
    chk("t6_done", 512'(done), 512'(1'b0));
    chk("t6_rstn", 512'(dut_rst_n), 512'(1'b0));
    chk("t6_dut_in", 512'(dut_in_flat), 512'(0));
    chk("t6_signature", 512'(signature), 512'(0));
    chk("t6_vec_cnt", 512'(vec_cnt), 512'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    do_start($urandom, 2, 1'b1);
    wait_sb(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
